// File: rtl/qa_driver_sreg_rsp_sched_pkg.sv
// Shared types for the SREG read sequencer: address type, FSM states, DSM response line layout.
// The optional response timeout is selected with QA_SREG_TIMEOUT_EN.
package qa_driver_csr_types;

  localparam int unsigned SREG_ADDR_W = 32;
  localparam int unsigned LINE_W      = 512;
  localparam int unsigned RSP_DATA_W  = 64;
  localparam int unsigned DSM_ADDR_W  = 64;
  localparam int unsigned TIMER_W     = 16;
  localparam int unsigned DROP_CNT_W  = 16;

  typedef logic [SREG_ADDR_W-1:0] t_sreg_addr;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    WRITE,
    WAIT_ACK
  } t_sreg_rsp_state;

  // Packed MSB-first: address sits at bits [96+:SREG_ADDR_W], value at [63:0].
  typedef struct packed {
    logic [LINE_W-96-SREG_ADDR_W-1:0] rsvd_hi;
    t_sreg_addr                       addr;
    logic [29:0]                      rsvd_mid;
    logic                             timeout;
    logic                             valid;
    logic [RSP_DATA_W-1:0]            value;
  } t_sreg_rsp_line;

  localparam logic [RSP_DATA_W-1:0] SREG_TIMEOUT_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

  function automatic t_sreg_rsp_line make_rsp_line(logic [RSP_DATA_W-1:0] value,
                                                   logic timeout, t_sreg_addr addr);
    t_sreg_rsp_line line;
    line         = '0;
    line.value   = value;
    line.valid   = 1'b1;
    line.timeout = timeout;
    line.addr    = addr;
    return line;
  endfunction

endpackage

// File: rtl/qa_driver_sreg_rsp_sched_if.sv
// CSR trigger, SREG source and c1 write channel signals of the SREG read sequencer.
interface qa_driver_sreg_rsp_sched_if;
  import qa_driver_csr_types::*;

  logic                    sreg_rd_strobe;
  t_sreg_addr              sreg_rd_addr;
  logic [DSM_ADDR_W-1:0]   dsm_base;
  logic                    dsm_base_valid;
  logic                    sreg_req_valid;
  t_sreg_addr              sreg_req_addr;
  logic                    sreg_rsp_valid;
  logic [RSP_DATA_W-1:0]   sreg_rsp_data;
  logic                    wr_valid;
  logic [DSM_ADDR_W-1:0]   wr_addr;
  logic [LINE_W-1:0]       wr_data;
  logic                    wr_almost_full;
  logic                    wr_ack;
  logic                    busy;
  logic [DROP_CNT_W-1:0]   drop_cnt;

  modport master (
    input  sreg_rd_strobe, sreg_rd_addr, dsm_base, dsm_base_valid,
    input  sreg_rsp_valid, sreg_rsp_data, wr_almost_full, wr_ack,
    output sreg_req_valid, sreg_req_addr, wr_valid, wr_addr, wr_data, busy, drop_cnt
  );

  modport slave (
    output sreg_rd_strobe, sreg_rd_addr, dsm_base, dsm_base_valid,
    output sreg_rsp_valid, sreg_rsp_data, wr_almost_full, wr_ack,
    input  sreg_req_valid, sreg_req_addr, wr_valid, wr_addr, wr_data, busy, drop_cnt
  );

endinterface

// File: rtl/qa_driver_sreg_rsp_sched.sv
// Sequences one SREG fetch per CSR strobe and posts the value as a DSM line write.
// Define QA_SREG_TIMEOUT_EN to enable the response timeout (TIMEOUT_CYCLES).
module qa_driver_sreg_rsp_sched
  import qa_driver_csr_types::*;
#(
  parameter int unsigned DSM_SREG_OFFSET = 1
`ifdef QA_SREG_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input logic                         clk,
  input logic                         reset_n,
  qa_driver_sreg_rsp_sched_if.master  bus
);

  t_sreg_rsp_state state;
  logic            pend_valid;
  t_sreg_addr      pend_addr;

  logic                  strobe_queued;
  logic                  pend_free;
  logic                  pend_fill;
  logic                  pend_drop;
  logic                  pend_nx;
  logic                  wr_ok;
  logic [DSM_ADDR_W-1:0] wr_addr_nx;

`ifdef QA_SREG_TIMEOUT_EN
  logic [TIMER_W-1:0] timer;
`endif

  // A strobe queues whenever it cannot start directly; the slot frees in the IDLE consume cycle.
  assign strobe_queued = bus.sreg_rd_strobe && ((state != IDLE) || pend_valid);
  assign pend_free     = !pend_valid || (state == IDLE);
  assign pend_fill     = strobe_queued && pend_free;
  assign pend_drop     = strobe_queued && !pend_free;
  assign pend_nx       = pend_fill || (pend_valid && (state != IDLE));
  assign wr_ok         = bus.dsm_base_valid && !bus.wr_almost_full;
  assign wr_addr_nx    = bus.dsm_base + DSM_ADDR_W'(DSM_SREG_OFFSET);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      pend_valid         <= 1'b0;
      pend_addr          <= '0;
      bus.sreg_req_valid <= 1'b0;
      bus.sreg_req_addr  <= '0;
      bus.wr_valid       <= 1'b0;
      bus.wr_addr        <= '0;
      bus.wr_data        <= '0;
      bus.busy           <= 1'b0;
      bus.drop_cnt       <= '0;
`ifdef QA_SREG_TIMEOUT_EN
      timer              <= '0;
`endif
    end else begin
      bus.sreg_req_valid <= 1'b0;

      if (pend_fill) begin
        pend_valid <= 1'b1;
        pend_addr  <= bus.sreg_rd_addr;
      end else if (state == IDLE) begin
        pend_valid <= 1'b0;
      end

      if (pend_drop && (bus.drop_cnt != '1)) begin
        bus.drop_cnt <= bus.drop_cnt + DROP_CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (pend_valid || bus.sreg_rd_strobe) begin
            state              <= REQ;
            bus.sreg_req_valid <= 1'b1;
            bus.sreg_req_addr  <= pend_valid ? pend_addr : bus.sreg_rd_addr;
            bus.busy           <= 1'b1;
`ifdef QA_SREG_TIMEOUT_EN
            timer              <= '0;
`endif
          end else begin
            bus.busy <= 1'b0;
          end
        end

        REQ: begin
          state <= WAIT_RSP;
`ifdef QA_SREG_TIMEOUT_EN
          timer <= timer + TIMER_W'(1);
`endif
        end

        // Write is launched straight from the response cycle when the channel is free.
        WAIT_RSP: begin
          if (bus.sreg_rsp_valid) begin
            state       <= WRITE;
            bus.wr_data <= LINE_W'(make_rsp_line(bus.sreg_rsp_data, 1'b0, bus.sreg_req_addr));
            if (wr_ok) begin
              bus.wr_valid <= 1'b1;
              bus.wr_addr  <= wr_addr_nx;
            end
`ifdef QA_SREG_TIMEOUT_EN
          end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= WRITE;
            bus.wr_data <= LINE_W'(make_rsp_line(SREG_TIMEOUT_DATA, 1'b1, bus.sreg_req_addr));
            if (wr_ok) begin
              bus.wr_valid <= 1'b1;
              bus.wr_addr  <= wr_addr_nx;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
`endif
          end
        end

        WRITE: begin
          if (bus.wr_valid) begin
            bus.wr_valid <= 1'b0;
            state        <= WAIT_ACK;
          end else if (wr_ok) begin
            bus.wr_valid <= 1'b1;
            bus.wr_addr  <= wr_addr_nx;
          end
        end

        WAIT_ACK: begin
          if (bus.wr_ack) begin
            state             <= IDLE;
            bus.sreg_req_addr <= '0;
            bus.busy          <= pend_nx;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
